// File: rtl/watch_pkg.sv
// Shared definitions for the watch: field widths, field maxima, the packed
// time record and the +/-1-with-wrap step used by every time field.
// The control unit and the display mux import this package as well.
package watch_pkg;

    // Field widths.
    localparam int MSEC_W  = 7;
    localparam int SEC_W   = 6;
    localparam int MIN_W   = 6;
    localparam int HOUR_W  = 5;

    // Widest field. Every field is widened to this width before stepping.
    localparam int FIELD_W = MSEC_W;

    // Field maxima. Each field wraps to zero after reaching its maximum.
    localparam logic [MSEC_W-1:0] MSEC_MAX = 7'd99;
    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

    // Complete time value, most significant field first.
    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
        logic [MSEC_W-1:0] msec;
    } watch_time_t;

    // Steps a field by one, wrapping inside the range 0..max_value.
    // The maximum is compared at full field width. A result at 0 or at the
    // maximum therefore never wraps through the unused upper codes.
    function automatic logic [FIELD_W-1:0] step_wrap(
        input logic [FIELD_W-1:0] value,
        input logic [FIELD_W-1:0] max_value,
        input logic               down
    );
        if (down) begin
            return (value == '0) ? max_value : value - FIELD_W'(1);
        end
        return (value == max_value) ? '0 : value + FIELD_W'(1);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Clock divider. It produces a one-cycle o_tick every DIV = CLK_FREQ_HZ/TICK_HZ
// running cycles. While i_run is low the count holds its value. i_restart sets
// the count back to zero. DIV must be an integer of 2 or more.
module tick_gen #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TICK_HZ     = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic i_run,
    input  logic i_restart,
    output logic o_tick
);

    localparam int DIV   = CLK_FREQ_HZ / TICK_HZ;
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_div_cnt;
    logic             w_at_last;

    assign w_at_last = (r_div_cnt == CNT_LAST);

    // The tick is combinational. It is high during the last running cycle,
    // so the field counters act on the same edge where the divider wraps.
    assign o_tick = i_run && w_at_last;

    // Divider count: restart clears it, running advances and wraps it, stopped holds it.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only. Other
        // processes then read the value from before the edge, whatever the
        // order the processes are evaluated in.
        if (reset) begin
            r_div_cnt <= '0;
        end else if (i_restart) begin
            r_div_cnt <= '0;
        end else if (i_run) begin
            r_div_cnt <= w_at_last ? '0 : r_div_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/watch_time_datapath.sv
// Watch time-keeping datapath. It keeps a cascaded hh:mm:ss.cc count that
// advances on centisecond ticks. It applies single-field set strobes and
// reloads INIT_HOUR:00:00.00 on clear.
// The order of precedence on each edge is: reset, then clear, then digit
// strobe, then tick.
// Optional feature: define WATCH_HOUR_CHIME_EN to add o_chime. o_chime pulses
// when counting carries the minutes from 59 to 0.
module watch_time_datapath
    import watch_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TICK_HZ     = 100,
    parameter int INIT_HOUR   = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_run_stop,
    input  logic              i_clear,
    input  logic              i_down,
    input  logic              i_hour_digit,
    input  logic              i_min_digit,
    input  logic              i_sec_digit,
    input  logic              i_msec_digit,
    output logic [MSEC_W-1:0] o_msec,
    output logic [SEC_W-1:0]  o_sec,
    output logic [MIN_W-1:0]  o_min,
    output logic [HOUR_W-1:0] o_hour,
    output logic              o_tick
`ifdef WATCH_HOUR_CHIME_EN
    ,
    output logic              o_chime
`endif
);

    localparam watch_time_t INIT_TIME = '{
        hour: HOUR_W'(INIT_HOUR),
        min:  MIN_W'(0),
        sec:  SEC_W'(0),
        msec: MSEC_W'(0)
    };

    watch_time_t r_time;
    watch_time_t w_next;
    logic        w_tick;
    logic        w_any_set;
    logic        w_count_en;

    // Clear also restarts the divider, so the first tick after a clear
    // comes one full period later.
    tick_gen #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .TICK_HZ     (TICK_HZ)
    ) u_tick_gen (
        .clk       (clk),
        .reset     (reset),
        .i_run     (i_run_stop),
        .i_restart (i_clear),
        .o_tick    (w_tick)
    );

    assign w_any_set  = i_hour_digit | i_min_digit | i_sec_digit | i_msec_digit;

    // A tick counts only when no clear or set strobe claims the edge.
    // Otherwise the tick is dropped, but the divider still wraps.
    assign w_count_en = w_tick && !i_clear && !w_any_set;

    // Next time value. Clear has priority over the strobes, which are tested
    // highest field first, and the tick cascade comes last.
    always_comb begin
        // NOTE: assigning the default before any branch means every path
        // drives w_next, so the block infers no latch.
        w_next = r_time;
        if (i_clear) begin
            w_next = INIT_TIME;
        end else if (i_hour_digit) begin
            w_next.hour = HOUR_W'(step_wrap(FIELD_W'(r_time.hour), FIELD_W'(HOUR_MAX), i_down));
        end else if (i_min_digit) begin
            w_next.min  = MIN_W'(step_wrap(FIELD_W'(r_time.min), FIELD_W'(MIN_MAX), i_down));
        end else if (i_sec_digit) begin
            w_next.sec  = SEC_W'(step_wrap(FIELD_W'(r_time.sec), FIELD_W'(SEC_MAX), i_down));
        end else if (i_msec_digit) begin
            w_next.msec = step_wrap(r_time.msec, MSEC_MAX, i_down);
        end else if (w_tick) begin
            w_next.msec = step_wrap(r_time.msec, MSEC_MAX, 1'b0);
            if (r_time.msec == MSEC_MAX) begin
                w_next.sec = SEC_W'(step_wrap(FIELD_W'(r_time.sec), FIELD_W'(SEC_MAX), 1'b0));
                if (r_time.sec == SEC_MAX) begin
                    w_next.min = MIN_W'(step_wrap(FIELD_W'(r_time.min), FIELD_W'(MIN_MAX), 1'b0));
                    if (r_time.min == MIN_MAX) begin
                        w_next.hour = HOUR_W'(step_wrap(FIELD_W'(r_time.hour), FIELD_W'(HOUR_MAX), 1'b0));
                    end
                end
            end
        end
    end

    // Time register. Reset returns every field to its initial value, so no
    // carry that is in progress survives the reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_time <= INIT_TIME;
        end else begin
            r_time <= w_next;
        end
    end

    assign o_hour = r_time.hour;
    assign o_min  = r_time.min;
    assign o_sec  = r_time.sec;
    assign o_msec = r_time.msec;
    assign o_tick = w_tick;

`ifdef WATCH_HOUR_CHIME_EN
    // The chime fires only on a counting carry out of minute 59. A set
    // strobe or a clear can never trigger it.
    assign o_chime = w_count_en
                  && (r_time.msec == MSEC_MAX)
                  && (r_time.sec  == SEC_MAX)
                  && (r_time.min  == MIN_MAX);
`else
    // Without the chime the gated tick only documents the drop rule.
    logic w_unused_count_en;
    assign w_unused_count_en = w_count_en;
`endif

endmodule

// File: tb/tb_watch_time_datapath.sv
// Scoreboard bench for watch_time_datapath. Parameters: CLK_FREQ_HZ=1000 and
// TICK_HZ=100, so DIV=10.
// The stimulus pushes the expected time and tick for the current cycle. A
// monitor on the falling edge pops each entry and compares it.
module tb_watch_time_datapath;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       clr = 1'b0;
    logic       down = 1'b0;
    logic       hd = 1'b0, md = 1'b0, sd = 1'b0, msd = 1'b0;
    logic [6:0] o_msec;
    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic [4:0] o_hour;
    logic       o_tick;
`ifdef WATCH_HOUR_CHIME_EN
    logic       o_chime;
`endif

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int    cyc;
        string name;
        int    h, m, s, c;
        bit    t;
        bit    ch;
    } exp_t;

    exp_t sb[$];

    watch_time_datapath #(
        .CLK_FREQ_HZ (1000),
        .TICK_HZ     (100),
        .INIT_HOUR   (12)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_run_stop   (run),
        .i_clear      (clr),
        .i_down       (down),
        .i_hour_digit (hd),
        .i_min_digit  (md),
        .i_sec_digit  (sd),
        .i_msec_digit (msd),
        .o_msec       (o_msec),
        .o_sec        (o_sec),
        .o_min        (o_min),
        .o_hour       (o_hour),
        .o_tick       (o_tick)
`ifdef WATCH_HOUR_CHIME_EN
        ,
        .o_chime      (o_chime)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every expectation that is due in this cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        bit   bad;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc < cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
            end else begin
                bad = (o_hour !== 5'(e.h)) || (o_min !== 6'(e.m)) || (o_sec !== 6'(e.s))
                   || (o_msec !== 7'(e.c)) || (o_tick !== e.t);
`ifdef WATCH_HOUR_CHIME_EN
                bad = bad || (o_chime !== e.ch);
`endif
                if (bad) begin
                    errors++;
                    $display("FAIL %s: got %0d:%0d:%0d.%0d tick=%0b, want %0d:%0d:%0d.%0d tick=%0b",
                             e.name, o_hour, o_min, o_sec, o_msec, o_tick,
                             e.h, e.m, e.s, e.c, e.t);
                end
            end
        end
    end

    // Advances one clock. Inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string name, input int h, input int m, input int s,
                              input int c, input bit t, input bit ch = 1'b0);
        exp_t e;
        e.cyc = cyc; e.name = name; e.h = h; e.m = m; e.s = s; e.c = c; e.t = t; e.ch = ch;
        sb.push_back(e);
    endtask

    // Strobe selector: 0 = hour, 1 = min, 2 = sec, 3 = msec.
    task automatic pulse(input int which);
        case (which)
            0: hd = 1'b1;
            1: md = 1'b1;
            2: sd = 1'b1;
            default: msd = 1'b1;
        endcase
        step();
        hd = 1'b0; md = 1'b0; sd = 1'b0; msd = 1'b0;
    endtask

    // Runs one divider period from a count of 0 and checks the tick position.
    task automatic tick_period(input string name, input int h, input int m, input int s, input int c);
        for (int i = 0; i < 10; i++) begin
            expect_now(name, h, m, s, c, i == 9);
            step();
        end
    endtask

    // Global timeout. The full run is well under a thousand cycles.
    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        step(); step();
        reset = 1'b0;
        expect_now("reset", 12, 0, 0, 0, 0);

        // 1: first tick on the 10th running cycle, then msec becomes 1
        run = 1'b1;
        tick_period("t1_tick", 12, 0, 0, 0);
        expect_now("t1_msec", 12, 0, 0, 1, 0);
        run = 1'b0;

        // 2: preload 12:59:59.99 and roll it to 13:00:00.00
        down = 1'b1;
        pulse(3); pulse(3); pulse(2); pulse(1);
        expect_now("t2_pre", 12, 59, 59, 99, 0);
        run = 1'b1;
        repeat (9) step();
        expect_now("t2_tickcyc", 12, 59, 59, 99, 1, 1'b1);
        step();
        expect_now("t2_roll", 13, 0, 0, 0, 0);
        run = 1'b0;

        // 2b: 23:59:59.99 rolls to 00:00:00.00
        down = 1'b0;
        repeat (10) pulse(0);
        down = 1'b1;
        pulse(3); pulse(2); pulse(1);
        expect_now("t2b_pre", 23, 59, 59, 99, 0);
        run = 1'b1;
        repeat (9) step();
        expect_now("t2b_tickcyc", 23, 59, 59, 99, 1, 1'b1);
        step();
        expect_now("t2b_roll", 0, 0, 0, 0, 0);
        run = 1'b0;

        // 3: set wraps inside each field without borrowing
        pulse(1);
        expect_now("t3_min_dn_wrap", 0, 59, 0, 0, 0);
        pulse(0);
        expect_now("t3_hour_dn_wrap", 23, 59, 0, 0, 0);
        down = 1'b0;
        pulse(0);
        expect_now("t3_hour_up_wrap", 0, 59, 0, 0, 0);
        down = 1'b1;
        pulse(2);
        expect_now("t3_sec_dn_wrap", 0, 59, 59, 0, 0);

        // 4: strobe priority, and a tick dropped by a strobe
        down = 1'b0;
        hd = 1'b1; sd = 1'b1;
        step();
        hd = 1'b0; sd = 1'b0;
        expect_now("t4_hour_over_sec", 1, 59, 59, 0, 0);
        hd = 1'b1; md = 1'b1; sd = 1'b1; msd = 1'b1;
        step();
        hd = 1'b0; md = 1'b0; sd = 1'b0; msd = 1'b0;
        expect_now("t4_hour_over_all", 2, 59, 59, 0, 0);
        run = 1'b1;
        repeat (9) step();
        sd = 1'b1;
        expect_now("t4_strobe_tickcyc", 2, 59, 59, 0, 1);
        step();
        sd = 1'b0;
        expect_now("t4_tick_dropped", 2, 59, 0, 0, 0);
        tick_period("t4_div_wrapped", 2, 59, 0, 0);
        expect_now("t4_next_count", 2, 59, 0, 1, 0);

        // 5: clear at msec=37 with div_cnt=6 restarts the divider
        repeat (360) step();
        repeat (6) step();
        expect_now("t5_pre", 2, 59, 0, 37, 0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        expect_now("t5_clear", 12, 0, 0, 0, 0);
        tick_period("t5_tick_after_clear", 12, 0, 0, 0);
        expect_now("t5_count", 12, 0, 0, 1, 0);

        // 6: reset while counting at 05:07:08.42, on a tick cycle
        run = 1'b0;
        down = 1'b1;
        repeat (7) pulse(0);
        down = 1'b0;
        repeat (7) pulse(1);
        repeat (8) pulse(2);
        repeat (41) pulse(3);
        expect_now("t6_pre", 5, 7, 8, 42, 0);
        run = 1'b1;
        repeat (9) step();
        expect_now("t6_tickcyc", 5, 7, 8, 42, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        expect_now("t6_reset", 12, 0, 0, 0, 0);
        tick_period("t6_div_zeroed", 12, 0, 0, 0);
        expect_now("t6_count", 12, 0, 0, 1, 0);

        run = 1'b0;
        repeat (3) step();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations never compared, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
